// File: rtl/knob_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : knob_step_decoder
//  Brief    : Quadrature encoder front end: sync, debounce, Gray decode and
//             detent accumulation into single-cycle inc/dec/err ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module knob_step_decoder #(
    parameter int DB_CYCLES       = 100000,
    parameter int COUNTS_PER_STEP = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    output logic       inc_tick,
    output logic       dec_tick,
    output logic       err_tick,
    output logic [4:0] position,
    output logic [1:0] dir_led
);

    localparam int                       CNT_W     = $clog2(DB_CYCLES);
    localparam int                       ACC_W     = $clog2(COUNTS_PER_STEP) + 2;
    localparam logic [CNT_W-1:0]         C_CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0]         C_CNT_ONE = CNT_W'(1);
    localparam logic signed [ACC_W-1:0]  C_ACC_MAX = ACC_W'(COUNTS_PER_STEP - 1);
    localparam logic signed [ACC_W-1:0]  C_ACC_MIN = -C_ACC_MAX;
    localparam logic signed [ACC_W-1:0]  C_ACC_ONE = ACC_W'(1);

    // Channel pairs are packed as {A, B} throughout.
    logic [1:0]             sync1_q;
    logic [1:0]             sync2_q;
    logic [1:0]             db_q;
    logic [1:0]             db_d;
    logic [1:0]             prev_q;
    logic [CNT_W-1:0]       cnt_q [2];
    logic [CNT_W-1:0]       cnt_d [2];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic [4:0]             pos_q;
    logic [4:0]             pos_d;
    logic [1:0]             dir_q;
    logic [1:0]             dir_d;
    logic                   inc_q;
    logic                   inc_d;
    logic                   dec_q;
    logic                   dec_d;
    logic                   err_q;
    logic                   err_d;

    logic [1:0]             w_idx_cur;
    logic [1:0]             w_idx_prev;
    logic [1:0]             w_delta;
    logic                   w_step_up;
    logic                   w_step_dn;
    logic                   w_illegal;

    always_ff @(posedge clk_100MHz) begin
        sync1_q <= {a_in, b_in};
        sync2_q <= sync1_q;
    end

    // The debounced value flips on the DB_CYCLES-th consecutive differing edge.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == C_CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + C_CNT_ONE;
                end
            end
        end
    end

    // Map the Gray sequence 00,01,11,10 to 0..3 so a CW step is +1 mod 4.
    assign w_idx_cur  = {db_q[1],   db_q[1]   ^ db_q[0]};
    assign w_idx_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign w_delta    = w_idx_cur - w_idx_prev;
    assign w_step_up  = (w_delta == 2'd1);
    assign w_step_dn  = (w_delta == 2'd3);
    assign w_illegal  = (w_delta == 2'd2);

    always_comb begin
        acc_d = acc_q;
        pos_d = pos_q;
        dir_d = dir_q;
        inc_d = 1'b0;
        dec_d = 1'b0;
        err_d = w_illegal;
        if (w_step_up) begin
            if (acc_q == C_ACC_MAX) begin
                acc_d = '0;
                inc_d = 1'b1;
                pos_d = pos_q + 5'd1;
                dir_d = 2'b10;
            end else begin
                acc_d = acc_q + C_ACC_ONE;
            end
        end else if (w_step_dn) begin
            if (acc_q == C_ACC_MIN) begin
                acc_d = '0;
                dec_d = 1'b1;
                pos_d = pos_q - 5'd1;
                dir_d = 2'b01;
            end else begin
                acc_d = acc_q - C_ACC_ONE;
            end
        end
    end

    // Reset seeds the debounced and previous pairs from the synchronizer so an
    // encoder resting anywhere produces no step when reset releases.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            db_q   <= sync2_q;
            prev_q <= sync2_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            acc_q  <= '0;
            pos_q  <= '0;
            dir_q  <= 2'b00;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            db_q   <= db_d;
            prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            acc_q  <= acc_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            inc_q  <= inc_d;
            dec_q  <= dec_d;
            err_q  <= err_d;
        end
    end

    assign inc_tick = inc_q;
    assign dec_tick = dec_q;
    assign err_tick = err_q;
    assign position = pos_q;
    assign dir_led  = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_knob_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_knob_step_decoder
//  Brief    : Self-checking bench for knob_step_decoder (DB_CYCLES=4, 4/step).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_knob_step_decoder;

    localparam int         DB      = 4;
    localparam int         CPS     = 4;
    localparam int         LATENCY = DB + 3;
    localparam logic [2:0] K_N     = 3'b000;
    localparam logic [2:0] K_INC   = 3'b100;
    localparam logic [2:0] K_DEC   = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b001;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a_in  = 1'b1;
    logic       b_in  = 1'b1;
    logic       inc_tick;
    logic       dec_tick;
    logic       err_tick;
    logic [4:0] position;
    logic [1:0] dir_led;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] kind;
        logic [4:0] pos;
        logic [1:0] dir;
        int         due;
    } exp_t;

    typedef struct {
        logic       a;
        logic       b;
        int         hold;
        logic [2:0] kind;
        logic [4:0] pos;
        logic [1:0] dir;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    knob_step_decoder #(
        .DB_CYCLES       (DB),
        .COUNTS_PER_STEP (CPS)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .inc_tick   (inc_tick),
        .dec_tick   (dec_tick),
        .err_tick   (err_tick),
        .position   (position),
        .dir_led    (dir_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Any tick pops the oldest expected event and must match it exactly.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (inc_tick || dec_tick || err_tick)) begin
                if (sb.size() == 0) begin
                    check("unexpected tick", int'({inc_tick, dec_tick, err_tick}), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tick kind",  int'({inc_tick, dec_tick, err_tick}), int'(e.kind));
                    check("tick pos",   int'(position), int'(e.pos));
                    check("tick dir",   int'(dir_led),  int'(e.dir));
                    check("tick cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic add(input logic a, input logic b, input int hold,
                       input logic [2:0] kind, input logic [4:0] pos, input logic [1:0] dir);
        vec_t v;
        v = '{a, b, hold, kind, pos, dir};
        vecs.push_back(v);
    endtask

    // Called at a negedge; inputs are held for exactly 'hold' cycles.
    task automatic apply(input vec_t v, input int idx);
        a_in = v.a;
        b_in = v.b;
        if (v.kind != K_N) begin
            exp_t e;
            e = '{v.kind, v.pos, v.dir, cyc + LATENCY};
            sb.push_back(e);
        end
        repeat (v.hold) @(negedge clk);
        check($sformatf("vec%0d position", idx), int'(position), int'(v.pos));
        check($sformatf("vec%0d dir_led", idx),  int'(dir_led),  int'(v.dir));
        check($sformatf("vec%0d pending events", idx), sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        // Step 2: full CW detent from 00
        add(0, 1, 20, K_N,   5'd0,  2'b00);
        add(1, 1, 20, K_N,   5'd0,  2'b00);
        add(1, 0, 20, K_N,   5'd0,  2'b00);
        add(0, 0, 20, K_INC, 5'd1,  2'b10);
        // Step 3: 3-cycle bounce on A must not register
        add(1, 0,  3, K_N,   5'd1,  2'b10);
        add(0, 0, 20, K_N,   5'd1,  2'b10);
        // Step 4: 3 CW then 3 CCW, then a full CW detent
        add(0, 1, 20, K_N,   5'd1,  2'b10);
        add(1, 1, 20, K_N,   5'd1,  2'b10);
        add(1, 0, 20, K_N,   5'd1,  2'b10);
        add(1, 1, 20, K_N,   5'd1,  2'b10);
        add(0, 1, 20, K_N,   5'd1,  2'b10);
        add(0, 0, 20, K_N,   5'd1,  2'b10);
        add(0, 1, 20, K_N,   5'd1,  2'b10);
        add(1, 1, 20, K_N,   5'd1,  2'b10);
        add(1, 0, 20, K_N,   5'd1,  2'b10);
        add(0, 0, 20, K_INC, 5'd2,  2'b10);
        // Step 5: three CCW detents (2 -> 1 -> 0 -> 31), then one CW (31 -> 0)
        for (int d = 0; d < 3; d++) begin
            add(1, 0, 20, K_N,   5'd2 - 5'(d), (d == 0) ? 2'b10 : 2'b01);
            add(1, 1, 20, K_N,   5'd2 - 5'(d), (d == 0) ? 2'b10 : 2'b01);
            add(0, 1, 20, K_N,   5'd2 - 5'(d), (d == 0) ? 2'b10 : 2'b01);
            add(0, 0, 20, K_DEC, 5'd1 - 5'(d), 2'b01);
        end
        add(0, 1, 20, K_N,   5'd31, 2'b01);
        add(1, 1, 20, K_N,   5'd31, 2'b01);
        add(1, 0, 20, K_N,   5'd31, 2'b01);
        add(0, 0, 20, K_INC, 5'd0,  2'b10);
        // Step 6: illegal 00 -> 11, then a legal CW detent starting at 11
        add(1, 1, 20, K_ERR, 5'd0,  2'b10);
        add(1, 0, 20, K_N,   5'd0,  2'b10);
        add(0, 0, 20, K_N,   5'd0,  2'b10);
        add(0, 1, 20, K_N,   5'd0,  2'b10);
        add(1, 1, 20, K_INC, 5'd1,  2'b10);

        // Reset with the encoder resting at 11
        reset = 1'b1;
        a_in  = 1'b1;
        b_in  = 1'b1;
        repeat (5) @(negedge clk);
        check("reset inc_tick", int'(inc_tick), 0);
        check("reset dec_tick", int'(dec_tick), 0);
        check("reset err_tick", int'(err_tick), 0);
        check("reset position", int'(position), 0);
        check("reset dir_led",  int'(dir_led),  0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("idle position", int'(position), 0);
        check("idle dir_led",  int'(dir_led),  0);
        check("idle err_tick", int'(err_tick), 0);

        // Leave a half-finished detent (+2), then reset to discard it
        apply('{1'b1, 1'b0, 20, K_N, 5'd0, 2'b00}, -2);
        apply('{1'b0, 1'b0, 20, K_N, 5'd0, 2'b00}, -1);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post-reset position", int'(position), 0);
        check("post-reset dir_led",  int'(dir_led),  0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        repeat (20) @(negedge clk);
        check("final pending events", sb.size(), 0);
        check("final position", int'(position), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
